// File: rtl/fpro_arb_pkg.sv
// Shared types and default widths for the two-master FPro bus arbiter.
package fpro_arb_pkg;

    localparam int ARB_ADDR_W = 21;
    localparam int ARB_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_ACK  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/fpro_bus_arbiter.sv
// Two-master round-robin arbiter onto a single FPro MMIO bus.
// Each transaction is IDLE (grant) -> BUS (one strobe cycle) -> ACK (one pulse).
module fpro_bus_arbiter
    import fpro_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    output logic [DATA_W-1:0] m0_rd_data,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              m1_ack,
    output logic              mmio_cs,
    output logic              mmio_wr,
    output logic              mmio_rd,
    output logic [ADDR_W-1:0] mmio_addr,
    output logic [DATA_W-1:0] mmio_wr_data,
    input  logic [DATA_W-1:0] mmio_rd_data,
    output logic              busy,
    output logic              grant_id
);

    arb_state_t        state_reg;
    logic              mmio_cs_reg;
    logic              mmio_wr_reg;
    logic              mmio_rd_reg;
    logic [ADDR_W-1:0] mmio_addr_reg;
    logic [DATA_W-1:0] mmio_wr_data_reg;
    logic [DATA_W-1:0] m0_rd_data_reg;
    logic [DATA_W-1:0] m1_rd_data_reg;
    logic              m0_ack_reg;
    logic              m1_ack_reg;
    logic              busy_reg;
    logic              grant_id_reg;

    logic              sel_next;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wr_data;

    // On a tie the master that did not win last time goes first.
    always_comb begin
        sel_next = 1'b0;
        if (m0_req && m1_req) begin
            sel_next = ~grant_id_reg;
        end else if (m1_req) begin
            sel_next = 1'b1;
        end
        sel_wr      = sel_next ? m1_wr      : m0_wr;
        sel_addr    = sel_next ? m1_addr    : m0_addr;
        sel_wr_data = sel_next ? m1_wr_data : m0_wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            mmio_cs_reg      <= 1'b0;
            mmio_wr_reg      <= 1'b0;
            mmio_rd_reg      <= 1'b0;
            mmio_addr_reg    <= '0;
            mmio_wr_data_reg <= '0;
            m0_rd_data_reg   <= '0;
            m1_rd_data_reg   <= '0;
            m0_ack_reg       <= 1'b0;
            m1_ack_reg       <= 1'b0;
            busy_reg         <= 1'b0;
            grant_id_reg     <= 1'b1;
        end else begin
            m0_ack_reg <= 1'b0;
            m1_ack_reg <= 1'b0;
            unique case (state_reg)
                ST_IDLE: begin
                    if (m0_req || m1_req) begin
                        // The mmio_* registers double as the latched request.
                        state_reg        <= ST_BUS;
                        busy_reg         <= 1'b1;
                        grant_id_reg     <= sel_next;
                        mmio_cs_reg      <= 1'b1;
                        mmio_wr_reg      <= sel_wr;
                        mmio_rd_reg      <= ~sel_wr;
                        mmio_addr_reg    <= sel_addr;
                        mmio_wr_data_reg <= sel_wr_data;
                    end
                end
                ST_BUS: begin
                    state_reg        <= ST_ACK;
                    mmio_cs_reg      <= 1'b0;
                    mmio_wr_reg      <= 1'b0;
                    mmio_rd_reg      <= 1'b0;
                    mmio_addr_reg    <= '0;
                    mmio_wr_data_reg <= '0;
                    if (mmio_rd_reg) begin
                        if (grant_id_reg) begin
                            m1_rd_data_reg <= mmio_rd_data;
                        end else begin
                            m0_rd_data_reg <= mmio_rd_data;
                        end
                    end
                    if (grant_id_reg) begin
                        m1_ack_reg <= 1'b1;
                    end else begin
                        m0_ack_reg <= 1'b1;
                    end
                end
                ST_ACK: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign mmio_cs      = mmio_cs_reg;
    assign mmio_wr      = mmio_wr_reg;
    assign mmio_rd      = mmio_rd_reg;
    assign mmio_addr    = mmio_addr_reg;
    assign mmio_wr_data = mmio_wr_data_reg;
    assign m0_rd_data   = m0_rd_data_reg;
    assign m1_rd_data   = m1_rd_data_reg;
    assign m0_ack       = m0_ack_reg;
    assign m1_ack       = m1_ack_reg;
    assign busy         = busy_reg;
    assign grant_id     = grant_id_reg;

endmodule

// File: doc/fpro_bus_arbiter.md
FPRO_BUS_ARBITER -- requirements
Module: fpro_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 21, FPro bus register address width.
REQ-002 Parameter DATA_W, default 32, FPro bus data width.
REQ-003 clk  in  1  system clock; single clock domain.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 mN_req  in  1  master N (N=0,1) transaction request, held high until mN_ack.
REQ-006 mN_wr  in  1  master N direction: 1 write, 0 read; valid while mN_req high.
REQ-007 mN_addr  in  ADDR_W  master N target address; valid while mN_req high.
REQ-008 mN_wr_data  in  DATA_W  master N write data; valid while mN_req high.
REQ-009 mN_rd_data  out  DATA_W  master N captured read data.
REQ-010 mN_ack  out  1  master N one-cycle completion pulse.
REQ-011 mmio_cs  out  1  FPro bus chip select.
REQ-012 mmio_wr  out  1  FPro bus write strobe.
REQ-013 mmio_rd  out  1  FPro bus read strobe.
REQ-014 mmio_addr  out  ADDR_W  FPro bus address.
REQ-015 mmio_wr_data  out  DATA_W  FPro bus write data.
REQ-016 mmio_rd_data  in  DATA_W  FPro bus read data, combinationally valid in the strobe cycle.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 grant_id  out  1  index of the master most recently granted.

Function
REQ-019 FSM SHALL have states IDLE, BUS, ACK; all outputs registered.
REQ-020 In IDLE, mN_req SHALL be sampled; with no request, the FSM SHALL remain in IDLE.
REQ-021 With exactly one request in IDLE, that master SHALL be granted.
REQ-022 With both requests in IDLE, the master != grant_id SHALL be granted (round-robin).
REQ-023 On grant, the master's wr/addr/wr_data SHALL be latched, grant_id updated, and the FSM SHALL enter BUS.
REQ-024 BUS SHALL last exactly one cycle: mmio_cs=1, exactly one of mmio_wr/mmio_rd=1, and mmio_addr/mmio_wr_data driven from the latched values; the FSM SHALL then enter ACK.
REQ-025 On a read, mmio_rd_data SHALL be captured at the end of BUS into the granted master's mN_rd_data.
REQ-026 mN_rd_data SHALL hold its value until that master's next read completes; writes SHALL NOT alter it.
REQ-027 In ACK, the granted master's mN_ack SHALL be high for exactly one cycle; the FSM SHALL then return to IDLE.
REQ-028 Latency: req sampled in IDLE at cycle t -> strobe at t+1 -> ack at t+2 -> next grant decision at t+3.
REQ-029 Outside BUS, mmio_cs/wr/rd SHALL be 0, and mmio_addr/mmio_wr_data SHALL be 0.
REQ-030 A request still high when sampled in IDLE after its ack SHALL be treated as a new transaction.
REQ-031 Request changes during BUS/ACK SHALL NOT affect the transaction in flight.
REQ-032 Only one mN_ack SHALL ever be high in a given cycle.

Reset
REQ-033 On reset: state=IDLE; mmio_*, mN_ack, busy=0; mN_rd_data=0; grant_id=1, so that m0 wins the first tie.
REQ-034 Reset during BUS or ACK SHALL abort the transaction with no ack issued, and strobes SHALL be 0 from the next cycle.

Structure
REQ-035 The state enum and the ADDR_W/DATA_W defaults SHALL reside in a shared package, fpro_arb_pkg.
REQ-036 The block SHALL be flat, with no sub-modules; it is instantiated between chu_mcs_bridge (m0) and mmio_sys_vanilla.

Verification
REQ-037 Single m0 write to addr 0x00040 with data 0xDEADBEEF -> one cycle of mmio_cs=1, mmio_wr=1 carrying those values; m0_ack 2 cycles after the sample.
REQ-038 m1 read of addr 0x00081 with bus returning 0x12345678 -> m1_rd_data=0x12345678 at the m1_ack cycle; m0_rd_data unchanged.
REQ-039 Both requests after reset, each held for 3 transactions -> grant order m0,m1,m0,m1,m0,m1; every transaction takes 3 cycles.
REQ-040 m0 holds req continuously while m1 is idle -> back-to-back m0 transactions every 3 cycles.
REQ-041 Reset asserted in BUS -> no ack issued, strobes 0 next cycle, grant_id=1, and a subsequent tie goes to m0.
REQ-042 Random stimulus -> at most one ack per cycle, strobes only in BUS, and no starvation beyond one transaction.
